paket_unpacker: RTL and testbench



---
 rtl/paket_pkg.sv | 28 ++
 rtl/paket_fifo.sv | 57 +++++
 rtl/paket_unpacker.sv | 142 ++++++++++++++
 tb/tb_paket_unpacker.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/paket_pkg.sv
// Shared field layout, response encodings and packet struct for the paket receive path.
package paket_pkg;

    localparam int unsigned TAG_MSB  = 35;
    localparam int unsigned TAG_LSB  = 34;
    localparam int unsigned RESP_MSB = 33;
    localparam int unsigned RESP_LSB = 32;
    localparam int unsigned DATA_MSB = 31;
    localparam int unsigned PAKET_W  = 36;
    localparam int unsigned N_PORTS  = 4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef struct packed {
        logic [1:0]  tag;
        logic [1:0]  resp;
        logic [31:0] data;
    } paket_t;

    // SLVERR and DECERR both carry resp[1] = 1.
    function automatic logic is_err_resp(input logic [1:0] resp);
        return resp[1];
    endfunction

endpackage

// File: rtl/paket_fifo.sv
// Per-port synchronous packet FIFO; DEPTH must be a power of two so pointers wrap naturally.
module paket_fifo
    import paket_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [PAKET_W-1:0]       wdata_i,
    input  logic                     pop_i,
    output logic [PAKET_W-1:0]       rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [PAKET_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]     count_q, count_d;

    always_comb begin
        count_d = count_q;
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/paket_unpacker.sv
// Four buffered packet ports arbitrated round-robin onto one registered decoded output.
// Optional resp-error counter enabled by defining PAKET_ERR_CNT_EN.
module paket_unpacker
    import paket_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [35:0] Paket_port1,
    input  logic [35:0] Paket_port2,
    input  logic [35:0] Paket_port3,
    input  logic [35:0] Paket_port4,
    input  logic        valid_port1,
    input  logic        valid_port2,
    input  logic        valid_port3,
    input  logic        valid_port4,
    output logic        ready_port1,
    output logic        ready_port2,
    output logic        ready_port3,
    output logic        ready_port4,
    output logic [31:0] out_data,
    output logic [1:0]  out_resp,
    output logic [1:0]  out_tag,
    output logic [1:0]  out_port,
    output logic        out_valid,
`ifdef PAKET_ERR_CNT_EN
    output logic [15:0] err_count,
`endif
    input  logic        out_ready
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [PAKET_W-1:0] pkt_in [N_PORTS];
    logic [PAKET_W-1:0] head   [N_PORTS];
    logic [PTR_W:0]     cnt    [N_PORTS];
    logic [N_PORTS-1:0] valid_in, push, pop, full, empty;

    logic [1:0]  rr_q, grant_idx, cand;
    logic        grant_vld, load;
    paket_t      head_sel;

    logic [31:0] out_data_q;
    logic [1:0]  out_resp_q, out_tag_q, out_port_q;
    logic        out_valid_q;

    assign pkt_in[0] = Paket_port1;
    assign pkt_in[1] = Paket_port2;
    assign pkt_in[2] = Paket_port3;
    assign pkt_in[3] = Paket_port4;
    assign valid_in  = {valid_port4, valid_port3, valid_port2, valid_port1};

    // Ready comes only from registered FIFO state, never from valid or out_ready.
    assign push = valid_in & ~full;

    for (genvar i = 0; i < N_PORTS; i++) begin : g_fifo
        paket_fifo #(
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .push_i  (push[i]),
            .wdata_i (pkt_in[i]),
            .pop_i   (pop[i]),
            .rdata_o (head[i]),
            .full_o  (full[i]),
            .empty_o (empty[i]),
            .count_o (cnt[i])
        );
    end

    logic unused_cnt;
    assign unused_cnt = ^{cnt[0], cnt[1], cnt[2], cnt[3]};

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = rr_q;
        cand      = '0;
        for (int k = 0; k < N_PORTS; k++) begin
            cand = rr_q + 2'(k);
            if (!grant_vld && !empty[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign load     = (!out_valid_q || out_ready) && grant_vld;
    assign head_sel = head[grant_idx];

    always_comb begin
        pop = '0;
        if (load) pop[grant_idx] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q        <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_resp_q  <= '0;
            out_tag_q   <= '0;
            out_port_q  <= '0;
        end else if (load) begin
            rr_q        <= grant_idx + 2'd1;
            out_valid_q <= 1'b1;
            out_data_q  <= head_sel.data;
            out_resp_q  <= head_sel.resp;
            out_tag_q   <= head_sel.tag;
            out_port_q  <= grant_idx;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

`ifdef PAKET_ERR_CNT_EN
    logic [15:0] err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= '0;
        end else if (load && is_err_resp(head_sel.resp) && (err_q != 16'hFFFF)) begin
            err_q <= err_q + 16'd1;
        end
    end

    assign err_count = err_q;
`endif

    assign ready_port1 = ~full[0];
    assign ready_port2 = ~full[1];
    assign ready_port3 = ~full[2];
    assign ready_port4 = ~full[3];

    assign out_data  = out_data_q;
    assign out_resp  = out_resp_q;
    assign out_tag   = out_tag_q;
    assign out_port  = out_port_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_paket_unpacker.sv
// Directed plus random bench for paket_unpacker against a queue-based reference model.
// Error-counter checks are compiled in when PAKET_ERR_CNT_EN is defined.
module tb_paket_unpacker;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [35:0] pk  [4];
    logic        vld [4];
    logic        rdy [4];
    logic [31:0] od;
    logic [1:0]  oresp, otag, oport;
    logic        ovalid, ordy;
`ifdef PAKET_ERR_CNT_EN
    logic [15:0] errc;
`endif

    always #5 clk = ~clk;

    paket_unpacker #(
        .DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .Paket_port1 (pk[0]),
        .Paket_port2 (pk[1]),
        .Paket_port3 (pk[2]),
        .Paket_port4 (pk[3]),
        .valid_port1 (vld[0]),
        .valid_port2 (vld[1]),
        .valid_port3 (vld[2]),
        .valid_port4 (vld[3]),
        .ready_port1 (rdy[0]),
        .ready_port2 (rdy[1]),
        .ready_port3 (rdy[2]),
        .ready_port4 (rdy[3]),
        .out_data    (od),
        .out_resp    (oresp),
        .out_tag     (otag),
        .out_port    (oport),
        .out_valid   (ovalid),
`ifdef PAKET_ERR_CNT_EN
        .err_count   (errc),
`endif
        .out_ready   (ordy)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: one queue per port plus the visible output slot.
    logic [35:0] mq [4][$];
    int          mrr;
    bit          mov;
    logic [31:0] md;
    logic [1:0]  mr, mt, mp;
    int          merr;
    bit          acc [4];

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mq[i].delete();
        mrr = 0; mov = 0; md = '0; mr = '0; mt = '0; mp = '0; merr = 0;
    endtask

    task automatic step();
        bit          rm [4];
        bit          any;
        logic [35:0] h;
        any = 0;
        for (int i = 0; i < 4; i++) begin
            rm[i] = mq[i].size() < DEPTH;
            chk($sformatf("ready%0d", i + 1), 36'(rdy[i]), 36'(rm[i]));
            if (mq[i].size() > 0) any = 1;
        end
        if ((!mov || ordy) && any) begin
            for (int k = 0; k < 4; k++) begin
                int p;
                p = (mrr + k) % 4;
                if (mq[p].size() > 0) begin
                    h    = mq[p].pop_front();
                    mt   = h[35:34];
                    mr   = h[33:32];
                    md   = h[31:0];
                    mp   = 2'(p);
                    mov  = 1;
                    mrr  = (p + 1) % 4;
                    if (h[33] && merr < 65535) merr++;
                    break;
                end
            end
        end else if (ordy) begin
            mov = 0;
        end
        for (int i = 0; i < 4; i++) begin
            acc[i] = vld[i] && rm[i];
            if (acc[i]) mq[i].push_back(pk[i]);
        end
        @(posedge clk);
        #1;
        chk("out_valid", 36'(ovalid), 36'(mov));
        chk("out_data", 36'(od), 36'(md));
        chk("out_resp", 36'(oresp), 36'(mr));
        chk("out_tag", 36'(otag), 36'(mt));
        chk("out_port", 36'(oport), 36'(mp));
`ifdef PAKET_ERR_CNT_EN
        chk("err_count", 36'(errc), 36'(merr));
`endif
    endtask

    task automatic do_reset();
        for (int i = 0; i < 4; i++) vld[i] = 0;
        rst = 1;
        #2;
        model_reset();
        chk("rst_out_valid", 36'(ovalid), 36'(0));
        for (int i = 0; i < 4; i++) chk($sformatf("rst_ready%0d", i + 1), 36'(rdy[i]), 36'(1));
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < 4; i++) vld[i] = 0;
        for (int c = 0; c < n; c++) step();
    endtask

    initial begin
        logic [31:0] seen [$];
        logic [31:0] prev;
        int          nxt;
        bit          hold [4];

        rst  = 1;
        ordy = 1;
        for (int i = 0; i < 4; i++) begin
            vld[i] = 0;
            pk[i]  = '0;
        end
        #1;
        model_reset();
        @(posedge clk);
        #1;
        chk("init_out_valid", 36'(ovalid), 36'(0));
        chk("init_out_data", 36'(od), 36'(0));
        chk("init_out_port", 36'(oport), 36'(0));
        rst = 0;

        // Single packet on port2.
        pk[1] = {2'b01, 2'b00, 32'hDEADBEEF};
        vld[1] = 1;
        step();
        vld[1] = 0;
        chk("lat_push_edge", 36'(ovalid), 36'(0));
        step();
        chk("lat_valid", 36'(ovalid), 36'(1));
        chk("lat_tag", 36'(otag), 36'(1));
        chk("lat_resp", 36'(oresp), 36'(0));
        chk("lat_data", 36'(od), 36'(32'hDEADBEEF));
        chk("lat_port", 36'(oport), 36'(1));
        step();
        chk("lat_clear", 36'(ovalid), 36'(0));

        // Four simultaneous pushes from pointer at port1.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            pk[i]  = {2'b00, 2'b00, 32'(i + 1)};
            vld[i] = 1;
        end
        step();
        for (int i = 0; i < 4; i++) vld[i] = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            chk("rr0_port", 36'(oport), 36'(c));
            chk("rr0_data", 36'(od), 36'(c + 1));
        end
        idle(2);

        // Move pointer to port3, then all four push.
        pk[1] = {2'b10, 2'b01, 32'h55};
        vld[1] = 1;
        step();
        idle(3);
        for (int i = 0; i < 4; i++) begin
            pk[i]  = {2'b11, 2'b00, 32'(i + 1)};
            vld[i] = 1;
        end
        step();
        for (int i = 0; i < 4; i++) vld[i] = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            chk("rr2_port", 36'(oport), 36'((c + 2) % 4));
        end
        idle(2);

        // Backpressure: five packets into port1 with output stalled.
        ordy = 0;
        for (int n = 0; n < 5; n++) begin
            pk[0]  = {2'b00, 2'b01, 32'(100 + n)};
            vld[0] = 1;
            step();
        end
        vld[0] = 0;
        step();
        chk("bp_ready_low", 36'(rdy[0]), 36'(0));
        chk("bp_hold_data", 36'(od), 36'(100));
        ordy = 1;
        seen.delete();
        if (ovalid) seen.push_back(od);
        for (int c = 0; c < 6; c++) begin
            step();
            if (ovalid) seen.push_back(od);
        end
        chk("bp_count", 36'(seen.size()), 36'(5));
        for (int n = 0; n < 5 && n < seen.size(); n++) chk("bp_order", 36'(seen[n]), 36'(100 + n));
        idle(2);

        // Sustained traffic through a full FIFO.
        ordy = 0;
        nxt  = 200;
        vld[0] = 1;
        for (int c = 0; c < 7; c++) begin
            pk[0] = {2'b00, 2'b00, 32'(nxt)};
            step();
            if (acc[0]) nxt++;
        end
        ordy = 1;
        prev = od;
        for (int c = 0; c < 16; c++) begin
            pk[0] = {2'b00, 2'b00, 32'(nxt)};
            step();
            if (acc[0]) nxt++;
            chk("thru_valid", 36'(ovalid), 36'(1));
            chk("thru_order", 36'(od), 36'(prev + 1));
            prev = od;
        end
        idle(8);

        // Reset with output valid and three entries buffered.
        ordy = 0;
        for (int n = 0; n < 4; n++) begin
            pk[2]  = {2'b01, 2'b01, 32'(300 + n)};
            vld[2] = 1;
            step();
        end
        vld[2] = 0;
        chk("pre_rst_valid", 36'(ovalid), 36'(1));
        do_reset();
        ordy = 1;
        idle(6);
        chk("post_rst_quiet", 36'(ovalid), 36'(0));

        // Random traffic with senders holding refused packets.
        for (int i = 0; i < 4; i++) hold[i] = 0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (!hold[i]) begin
                    vld[i] = ($urandom_range(0, 2) != 0);
                    pk[i]  = {$urandom(), $urandom()} & 36'hF_FFFF_FFFF;
                end
            end
            ordy = ($urandom_range(0, 3) != 0);
            step();
            for (int i = 0; i < 4; i++) hold[i] = vld[i] && !acc[i];
        end
        ordy = 1;
        idle(20);

`ifdef PAKET_ERR_CNT_EN
        do_reset();
        ordy = 1;
        for (int n = 0; n < 4; n++) begin
            logic [1:0] rs [4];
            rs = '{2'b00, 2'b10, 2'b11, 2'b01};
            pk[0]  = {2'b00, rs[n], 32'(n)};
            vld[0] = 1;
            step();
        end
        idle(4);
        chk("err_two", 36'(errc), 36'(2));
        for (int i = 0; i < 4; i++) begin
            pk[i]  = {2'b00, 2'b10, 32'hE0};
            vld[i] = 1;
        end
        for (int c = 0; c < 65540; c++) step();
        idle(4);
        chk("err_sat", 36'(errc), 36'(16'hFFFF));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
